// File: rtl/axi_read_slave_pkg.sv
// Shared AXI read-slave definitions: burst/response codes, FSM state,
// queued AR entry layout and the per-beat address stepping helper.
package axi_read_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Queue entries carry the widest supported id/address; the top zero-extends.
  localparam int AR_ID_MAX   = 16;
  localparam int AR_ADDR_MAX = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [AR_ID_MAX-1:0]   id;
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
  } ar_entry_t;

  function automatic logic [AR_ADDR_MAX-1:0] next_addr(
    input logic [AR_ADDR_MAX-1:0] addr,
    input logic [7:0]             len,
    input logic [2:0]             size,
    input logic [1:0]             burst
  );
    logic [AR_ADDR_MAX-1:0] inc;
    logic [AR_ADDR_MAX-1:0] win;
    inc = 64'd1 << size;
    win = (64'(len) + 64'd1) << size;
    case (burst)
      BURST_INCR: next_addr = addr + inc;
      // Stay inside the aligned (len+1)<<size window, wrapping to its base.
      BURST_WRAP: next_addr = (addr & ~(win - 64'd1)) | ((addr + inc) & (win - 64'd1));
      default:    next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_rslave_fifo.sv
// Two-entry synchronous FIFO used for both the AR queue and the R buffer.
module axi_rslave_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read slave: 2-deep AR queue, one-beat-per-cycle issue FSM over a
// 1-cycle-latency memory port, and a 2-deep R buffer guarded by credits.
module axi_read_slave
  import axi_read_slave_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTE  = 8,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  input  logic [ID_WIDTH-1:0]          ar_id,
  input  logic [ADDR_WIDTH-1:0]        ar_addr,
  input  logic [7:0]                   ar_len,
  input  logic [2:0]                   ar_size,
  input  logic [1:0]                   ar_burst,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [ID_WIDTH-1:0]          r_id,
  output logic [DATA_BYTE*8-1:0]       r_data,
  output logic [1:0]                   r_resp,
  output logic                         r_last,
  output logic                         mem_ren,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
  input  logic [DATA_BYTE*8-1:0]       mem_rdata,
  output state_e                       dbg_state
);

  localparam int DW         = DATA_BYTE * 8;
  localparam int BYTE_SHIFT = $clog2(DATA_BYTE);
  localparam int MAW        = $clog2(MEM_DEPTH);
  localparam int AR_W       = $bits(ar_entry_t);
  localparam int RW         = ID_WIDTH + DW + 3;

  // Handshakes: a transfer happens on a posedge where valid && ready; the
  // sender keeps valid and its payload stable until that edge.

  ar_entry_t       ar_in, ar_head;
  logic [AR_W-1:0] ar_head_bits;
  logic            ar_push, ar_pop, ar_empty, ar_full;
  logic [1:0]      ar_count;

  always_comb begin
    ar_in       = '0;
    ar_in.id    = AR_ID_MAX'(ar_id);
    ar_in.addr  = AR_ADDR_MAX'(ar_addr);
    ar_in.len   = ar_len;
    ar_in.size  = ar_size;
    ar_in.burst = ar_burst;
  end

  assign ar_ready = !rst && !ar_full;
  assign ar_push  = ar_valid && ar_ready;
  assign ar_head  = ar_entry_t'(ar_head_bits);

  axi_rslave_fifo #(.W(AR_W)) u_ar_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ar_push),
    .pop   (ar_pop),
    .din   (ar_in),
    .dout  (ar_head_bits),
    .empty (ar_empty),
    .full  (ar_full),
    .count (ar_count)
  );

  state_e                state, state_nxt;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            cur_len, beat_cnt;
  logic [2:0]            cur_size;
  logic [1:0]            cur_burst;
  logic                  in_burst, credit, issue, step, load_fresh;

  // In IDLE the queue head is issued directly so the first beat costs no cycle.
  logic [ID_WIDTH-1:0]   src_id;
  logic [ADDR_WIDTH-1:0] src_addr, nxt_addr, word_idx;
  logic [7:0]            src_len, src_beat;
  logic [2:0]            src_size;
  logic [1:0]            src_burst, beat_resp;
  logic                  src_last, slverr, decerr, beat_ok;

  assign in_burst  = (state == ST_BURST);
  assign src_id    = in_burst ? cur_id    : ar_head.id[ID_WIDTH-1:0];
  assign src_addr  = in_burst ? cur_addr  : ar_head.addr[ADDR_WIDTH-1:0];
  assign src_len   = in_burst ? cur_len   : ar_head.len;
  assign src_size  = in_burst ? cur_size  : ar_head.size;
  assign src_burst = in_burst ? cur_burst : ar_head.burst;
  assign src_beat  = in_burst ? beat_cnt  : 8'd0;
  assign src_last  = (src_beat == src_len);
  assign nxt_addr  = ADDR_WIDTH'(next_addr(AR_ADDR_MAX'(src_addr), src_len, src_size, src_burst));

  assign word_idx  = src_addr >> BYTE_SHIFT;
  assign slverr    = (src_burst == BURST_RSVD) || (src_size > 3'(BYTE_SHIFT)) ||
                     ((src_burst == BURST_WRAP) && !((src_len == 8'd1) || (src_len == 8'd3) ||
                                                     (src_len == 8'd7) || (src_len == 8'd15)));
  assign decerr    = (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
  assign beat_ok   = !slverr && !decerr;
  assign beat_resp = slverr ? RESP_SLVERR : (decerr ? RESP_DECERR : RESP_OKAY);

  logic                inf_valid, inf_ok, inf_last;
  logic [ID_WIDTH-1:0] inf_id;
  logic [1:0]          inf_resp, r_count;
  logic [2:0]          occ;
  logic                r_push, r_pop, r_empty, r_full;
  logic [RW-1:0]       r_in, r_head;

  // A slot freed by this cycle's pop may be claimed by this cycle's issue.
  assign occ     = {1'b0, r_count} + {2'b0, inf_valid};
  assign credit  = occ < ({2'b0, r_pop} + 3'd2);
  assign issue   = !rst && (in_burst || !ar_empty) && credit;
  assign mem_ren   = issue && beat_ok;
  assign mem_raddr = MAW'(word_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue && !src_last) state_nxt = ST_BURST;
      ST_BURST: if (issue && src_last && ar_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ar_pop     = 1'b0;
    step       = 1'b0;
    load_fresh = 1'b0;
    case (state)
      ST_IDLE: if (issue) begin
        ar_pop = 1'b1;
        step   = 1'b1;
      end
      ST_BURST: if (issue) begin
        if (!src_last)      step = 1'b1;
        else if (!ar_empty) begin
          ar_pop     = 1'b1;
          load_fresh = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      beat_cnt  <= '0;
    end else if (load_fresh) begin
      cur_id    <= ar_head.id[ID_WIDTH-1:0];
      cur_addr  <= ar_head.addr[ADDR_WIDTH-1:0];
      cur_len   <= ar_head.len;
      cur_size  <= ar_head.size;
      cur_burst <= ar_head.burst;
      beat_cnt  <= 8'd0;
    end else if (step) begin
      cur_id    <= src_id;
      cur_addr  <= nxt_addr;
      cur_len   <= src_len;
      cur_size  <= src_size;
      cur_burst <= src_burst;
      beat_cnt  <= src_beat + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inf_valid <= 1'b0;
      inf_ok    <= 1'b0;
      inf_last  <= 1'b0;
      inf_id    <= '0;
      inf_resp  <= '0;
    end else begin
      inf_valid <= issue;
      inf_ok    <= beat_ok;
      inf_last  <= src_last;
      inf_id    <= src_id;
      inf_resp  <= beat_resp;
    end
  end

  assign r_push = inf_valid;
  assign r_in   = {inf_id, (inf_ok ? mem_rdata : {DW{1'b0}}), inf_resp, inf_last};
  assign r_pop  = r_valid && r_ready;

  axi_rslave_fifo #(.W(RW)) u_r_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .pop   (r_pop),
    .din   (r_in),
    .dout  (r_head),
    .empty (r_empty),
    .full  (r_full),
    .count (r_count)
  );

  assign r_valid = !r_empty;
  assign r_id    = r_empty ? '0 : r_head[RW-1 -: ID_WIDTH];
  assign r_data  = r_empty ? '0 : r_head[DW+2:3];
  assign r_resp  = r_empty ? '0 : r_head[2:1];
  assign r_last  = r_empty ? 1'b0 : r_head[0];

  logic fifo_unused;
  assign fifo_unused = ^{ar_head, ar_count, r_full};

endmodule
